ci_issuer: RTL and testbench

Custom-instruction initiator: accepts a queued command (ciN, valueA, valueB) over a valid/ready handshake, drives the CPU-side custom-instruction protocol (ciStart pulse, held operands) toward any responder block, waits for ciDone, and returns the captured ciResult over a second valid/ready handshake. It sits wherever a non-CPU master, such as a test sequencer or the DMA control path, must exercise custom-instruction responders. Each transaction carries a timeout and a latency measurement.

---
 rtl/ci_issuer.sv | 160 ++++++++++++++++
 tb/tb_ci_issuer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_issuer.sv
// ci_issuer: custom-instruction initiator.
// Takes one queued command, issues it on the CPU-side custom-instruction
// interface (ciStart pulse plus held operands), waits for ciDone or a timeout,
// and returns the captured result with its start-to-done latency.
module ci_issuer #(
   parameter logic [15:0] timeoutCycles = 16'd255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [7:0]  cmdN,
   input  logic [31:0] cmdValueA,
   input  logic [31:0] cmdValueB,
   output logic        ciStart,
   output logic [7:0]  ciN,
   output logic [31:0] ciValueA,
   output logic [31:0] ciValueB,
   input  logic        ciDone,
   input  logic [31:0] ciResult,
   output logic        rspValid,
   input  logic        rspReady,
   output logic [31:0] rspResult,
   output logic        rspTimeout,
   output logic [15:0] rspCycles,
   output logic        spuriousDone
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  n_q, n_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        timeout_q, timeout_d;
   logic [15:0] cycles_q, cycles_d;
   logic        spurious_q, spurious_d;

   logic [15:0] cnt_inc;
   logic        ci_active;
   logic        wait_expired;

   // Latency counter saturates instead of wrapping.
   assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign wait_expired = (timeoutCycles != 16'd0) && (cnt_q == timeoutCycles);
   assign ci_active    = (state_q == S_ISSUE) || (state_q == S_WAIT);

   // Outputs are decoded from state only; reset gates cmdReady so it reads 0
   // while reset is held.
   assign cmdReady     = (state_q == S_IDLE) && reset;
   assign ciStart      = (state_q == S_ISSUE);
   assign ciN          = ci_active ? n_q : 8'd0;
   assign ciValueA     = ci_active ? a_q : 32'd0;
   assign ciValueB     = ci_active ? b_q : 32'd0;
   assign rspValid     = (state_q == S_RESP);
   assign rspResult    = result_q;
   assign rspTimeout   = timeout_q;
   assign rspCycles    = cycles_q;
   assign spuriousDone = spurious_q;

   // Next-state and datapath update for one transaction.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      n_d        = n_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      timeout_d  = timeout_q;
      cycles_d   = cycles_q;
      spurious_d = spurious_q | (ciDone & ~ci_active);

      case (state_q)
         S_IDLE: begin
            if (cmdValid) begin
               n_d     = cmdN;
               a_d     = cmdValueA;
               b_d     = cmdValueB;
               cnt_d   = 16'd1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ciDone) begin
               result_d  = ciResult;
               timeout_d = 1'b0;
               cycles_d  = 16'd1;
               state_d   = S_RESP;
            end else if (timeoutCycles == 16'd1) begin
               result_d  = 32'd0;
               timeout_d = 1'b1;
               cycles_d  = 16'd1;
               state_d   = S_RESP;
            end else begin
               cnt_d   = cnt_inc;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Completion wins over a timeout landing in the same cycle.
            if (ciDone) begin
               result_d  = ciResult;
               timeout_d = 1'b0;
               cycles_d  = cnt_q;
               state_d   = S_RESP;
            end else if (wait_expired) begin
               result_d  = 32'd0;
               timeout_d = 1'b1;
               cycles_d  = cnt_q;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_RESP: begin
            if (rspReady) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any transaction in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         n_q        <= 8'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         cnt_q      <= 16'd0;
         result_q   <= 32'd0;
         timeout_q  <= 1'b0;
         cycles_q   <= 16'd0;
         spurious_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         n_q        <= n_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         timeout_q  <= timeout_d;
         cycles_q   <= cycles_d;
         spurious_q <= spurious_d;
      end
   end

endmodule

// File: tb/tb_ci_issuer.sv
// Self-checking bench for ci_issuer: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model.
module tb_ci_issuer;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic [7:0]  cmdN = '0;
   logic [31:0] cmdValueA = '0;
   logic [31:0] cmdValueB = '0;
   logic        ciStart;
   logic [7:0]  ciN;
   logic [31:0] ciValueA;
   logic [31:0] ciValueB;
   logic        ciDone = 1'b0;
   logic [31:0] ciResult = '0;
   logic        rspValid;
   logic        rspReady = 1'b0;
   logic [31:0] rspResult;
   logic        rspTimeout;
   logic [15:0] rspCycles;
   logic        spuriousDone;

   int total = 0;
   int bad   = 0;

   ci_issuer #(.timeoutCycles(16'(TO))) dut (
      .clock(clock), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdN(cmdN), .cmdValueA(cmdValueA), .cmdValueB(cmdValueB),
      .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
      .ciDone(ciDone), .ciResult(ciResult),
      .rspValid(rspValid), .rspReady(rspReady),
      .rspResult(rspResult), .rspTimeout(rspTimeout), .rspCycles(rspCycles),
      .spuriousDone(spuriousDone)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // A transaction is either in flight (m_active, m_k = index of the current
   // cycle counted from the start cycle = 1) or has a response waiting.
   bit          m_active, m_rsp, m_spur;
   int          m_k;
   logic [7:0]  m_n;
   logic [31:0] m_a, m_b, e_res;
   bit          e_to;
   int          e_cyc;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_active = 0; m_rsp = 0; m_spur = 0; m_k = 0;
         m_n = '0; m_a = '0; m_b = '0;
         e_res = '0; e_to = 0; e_cyc = 0;
      end else if (m_active) begin
         if (ciDone) begin
            m_active = 0; m_rsp = 1; e_res = ciResult; e_to = 0; e_cyc = m_k;
         end else if (TO != 0 && m_k == TO) begin
            m_active = 0; m_rsp = 1; e_res = '0; e_to = 1; e_cyc = m_k;
         end else if (m_k < 65535) begin
            m_k = m_k + 1;
         end
      end else begin
         if (ciDone) m_spur = 1;
         if (m_rsp) begin
            if (rspReady) m_rsp = 0;
         end else if (cmdValid) begin
            m_active = 1; m_k = 1; m_n = cmdN; m_a = cmdValueA; m_b = cmdValueB;
         end
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clock) begin
      check("cmdReady",     {31'd0, cmdReady},     {31'd0, reset && !m_active && !m_rsp});
      check("ciStart",      {31'd0, ciStart},      {31'd0, m_active && m_k == 1});
      check("ciN",          {24'd0, ciN},          m_active ? {24'd0, m_n} : 32'd0);
      check("ciValueA",     ciValueA,              m_active ? m_a : 32'd0);
      check("ciValueB",     ciValueB,              m_active ? m_b : 32'd0);
      check("rspValid",     {31'd0, rspValid},     {31'd0, m_rsp});
      check("rspResult",    rspResult,             e_res);
      check("rspTimeout",   {31'd0, rspTimeout},   {31'd0, e_to});
      check("rspCycles",    {16'd0, rspCycles},    32'(e_cyc));
      check("spuriousDone", {31'd0, spuriousDone}, {31'd0, m_spur});
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a command and hold it until accepted (bounded); on return the
   // DUT is in its start cycle.
   task automatic send_cmd(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      cmdValid = 1'b1; cmdN = n; cmdValueA = a; cmdValueB = b;
      while (!cmdReady && w < 20) begin
         tick();
         w++;
      end
      check("cmd_accept", {31'd0, cmdReady}, 32'd1);
      tick();
      cmdValid = 1'b0;
   endtask

   task automatic drain();
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
   endtask

   initial begin
      // Reset values while reset is held.
      tick();
      check("rst_cmdReady", {31'd0, cmdReady}, 32'd0);
      check("rst_rspValid", {31'd0, rspValid}, 32'd0);
      check("rst_ciStart",  {31'd0, ciStart},  32'd0);
      tick();
      reset = 1'b1;
      tick();
      check("idle_cmdReady", {31'd0, cmdReady}, 32'd1);

      // Zero-wait responder.
      send_cmd(8'h05, 32'h0000_0200, 32'hDEAD_BEEF);
      check("zw_ciStart", {31'd0, ciStart}, 32'd1);
      check("zw_ciValueA", ciValueA, 32'h0000_0200);
      ciDone = 1'b1; ciResult = 32'h0BAD_F00D;
      tick();
      ciDone = 1'b0;
      check("zw_rspValid", {31'd0, rspValid}, 32'd1);
      check("zw_ciStart_off", {31'd0, ciStart}, 32'd0);
      check("zw_rspCycles", {16'd0, rspCycles}, 32'd1);
      check("zw_rspTimeout", {31'd0, rspTimeout}, 32'd0);
      drain();

      // Read-latency responder: done two cycles after the start cycle.
      send_cmd(8'h21, 32'h1111_0000, 32'h2222_0000);
      tick();
      tick();
      check("rl_held_A", ciValueA, 32'h1111_0000);
      check("rl_held_B", ciValueB, 32'h2222_0000);
      ciDone = 1'b1; ciResult = 32'h1234_5678;
      tick();
      ciDone = 1'b0;
      check("rl_rspResult", rspResult, 32'h1234_5678);
      check("rl_rspCycles", {16'd0, rspCycles}, 32'd3);
      check("rl_ci_cleared", ciValueA, 32'd0);
      drain();

      // Timeout: ciDone never comes.
      send_cmd(8'h33, 32'hCAFE_0001, 32'hCAFE_0002);
      begin
         int w = 0;
         while (!rspValid && w < 20) begin
            tick();
            w++;
         end
         check("to_rspValid", {31'd0, rspValid}, 32'd1);
         check("to_latency", 32'(w), 32'd4);
      end
      check("to_rspTimeout", {31'd0, rspTimeout}, 32'd1);
      check("to_rspResult", rspResult, 32'd0);
      check("to_rspCycles", {16'd0, rspCycles}, 32'd4);
      drain();

      // Tie: done in the 4th counted cycle is a completion.
      send_cmd(8'h44, 32'h4, 32'h5);
      tick();
      tick();
      tick();
      ciDone = 1'b1; ciResult = 32'hA5A5_A5A5;
      tick();
      ciDone = 1'b0;
      check("tie_rspTimeout", {31'd0, rspTimeout}, 32'd0);
      check("tie_rspResult", rspResult, 32'hA5A5_A5A5);
      check("tie_rspCycles", {16'd0, rspCycles}, 32'd4);

      // Backpressure with a spurious done during the response.
      cmdValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ciDone = (i == 2);
         tick();
         check("bp_cmdReady", {31'd0, cmdReady}, 32'd0);
         check("bp_rspResult", rspResult, 32'hA5A5_A5A5);
      end
      ciDone = 1'b0;
      cmdValid = 1'b0;
      check("bp_spurious", {31'd0, spuriousDone}, 32'd1);
      drain();
      check("bp_back_idle", {31'd0, cmdReady}, 32'd1);
      tick();
      check("bp_spurious_sticky", {31'd0, spuriousDone}, 32'd1);

      // Async reset in WAIT.
      send_cmd(8'h66, 32'h6666_6666, 32'h7777_7777);
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("ar_ciStart", {31'd0, ciStart}, 32'd0);
      check("ar_ciN", {24'd0, ciN}, 32'd0);
      check("ar_ciValueA", ciValueA, 32'd0);
      check("ar_rspValid", {31'd0, rspValid}, 32'd0);
      check("ar_spurious_clr", {31'd0, spuriousDone}, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      ciDone = 1'b1;
      tick();
      ciDone = 1'b0;
      check("ar_late_done", {31'd0, spuriousDone}, 32'd1);
      send_cmd(8'h77, 32'h1, 32'h2);
      tick();
      ciDone = 1'b1; ciResult = 32'h0000_BEEF;
      tick();
      ciDone = 1'b0;
      check("ar_new_rspCycles", {16'd0, rspCycles}, 32'd2);
      check("ar_new_rspResult", rspResult, 32'h0000_BEEF);
      drain();

      // Random traffic, checked each cycle by the model compare.
      for (int i = 0; i < 600; i++) begin
         cmdValid  = ($urandom_range(0, 1) == 1);
         cmdN      = 8'($urandom);
         cmdValueA = $urandom;
         cmdValueB = $urandom;
         ciDone    = ($urandom_range(0, 4) == 0);
         ciResult  = $urandom;
         rspReady  = ($urandom_range(0, 2) != 0);
         tick();
      end
      cmdValid = 1'b0; ciDone = 1'b0; rspReady = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
